// File: rtl/sw_cmd_arbiter_if.sv
// Command handshake bundle between two requesters and sw_cmd_arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface sw_cmd_arbiter_if;
   logic       req0_valid;
   logic       req1_valid;
   logic [1:0] req0_cmd;
   logic [1:0] req1_cmd;
   logic       ack0;
   logic       ack1;
   logic       resp_err;

   modport master (
      output req0_valid, req1_valid, req0_cmd, req1_cmd,
      input  ack0, ack1, resp_err
   );

   modport slave (
      input  req0_valid, req1_valid, req0_cmd, req1_cmd,
      output ack0, ack1, resp_err
   );
endinterface

// File: rtl/sw_cmd_arbiter.sv
// Round-robin arbiter for two stopwatch command requesters with a run/pause FSM.
// Define SWCTRL_LAP_EN to accept lap commands in RUN/PAUSE and capture the live time.
module sw_cmd_arbiter (
   input  logic                  clk,
   input  logic                  rst_n,
   sw_cmd_arbiter_if.slave       bus,
   output logic                  sw_start,
   output logic                  sw_stop,
   output logic                  sw_reset,
   input  logic [7:0]            minutes,
   input  logic [5:0]            seconds,
   output logic [7:0]            lap_min,
   output logic [5:0]            lap_sec,
   output logic                  lap_valid,
   output logic [1:0]            ctrl_state
);

`ifdef SWCTRL_LAP_EN
   localparam bit LapEn = 1'b1;
`else
   localparam bit LapEn = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      CMD_LAP   = 2'b00,
      CMD_START = 2'b01,
      CMD_STOP  = 2'b10,
      CMD_RESET = 2'b11
   } cmd_e;

   state_e     state_q, state_d;
   logic       ptr_q, ptr_d;
   logic       ack0_q, ack0_d;
   logic       ack1_q, ack1_d;
   logic       err_q, err_d;
   logic       start_q, start_d;
   logic       stop_q, stop_d;
   logic       reset_q, reset_d;
   logic [7:0] lap_min_q, lap_min_d;
   logic [5:0] lap_sec_q, lap_sec_d;
   logic       lap_valid_q, lap_valid_d;

   logic       elig0, elig1, gnt0, gnt1;
   cmd_e       cmd;

   always_comb begin
      // A port whose ack is currently high is still holding valid from the granted command.
      elig0 = bus.req0_valid & ~ack0_q;
      elig1 = bus.req1_valid & ~ack1_q;
      gnt0  = elig0 & (~elig1 | ~ptr_q);
      gnt1  = elig1 & ~gnt0;
      cmd   = cmd_e'(gnt0 ? bus.req0_cmd : bus.req1_cmd);

      state_d     = state_q;
      ptr_d       = ptr_q;
      ack0_d      = gnt0;
      ack1_d      = gnt1;
      err_d       = 1'b0;
      start_d     = 1'b0;
      stop_d      = 1'b0;
      reset_d     = 1'b0;
      lap_min_d   = lap_min_q;
      lap_sec_d   = lap_sec_q;
      lap_valid_d = lap_valid_q;

      if (gnt0 | gnt1) begin
         ptr_d = gnt0;
         case (cmd)
            CMD_START: begin
               if (state_q == RUN) begin
                  err_d = 1'b1;
               end else begin
                  start_d = 1'b1;
                  state_d = RUN;
               end
            end
            CMD_STOP: begin
               if (state_q == RUN) begin
                  stop_d  = 1'b1;
                  state_d = PAUSE;
               end else begin
                  err_d = 1'b1;
               end
            end
            CMD_RESET: begin
               reset_d     = 1'b1;
               state_d     = IDLE;
               lap_min_d   = '0;
               lap_sec_d   = '0;
               lap_valid_d = 1'b0;
            end
            default: begin
               if (LapEn && (state_q != IDLE)) begin
                  lap_min_d   = minutes;
                  lap_sec_d   = seconds;
                  lap_valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         err_q       <= 1'b0;
         start_q     <= 1'b0;
         stop_q      <= 1'b0;
         reset_q     <= 1'b0;
         lap_min_q   <= '0;
         lap_sec_q   <= '0;
         lap_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         err_q       <= err_d;
         start_q     <= start_d;
         stop_q      <= stop_d;
         reset_q     <= reset_d;
         lap_min_q   <= lap_min_d;
         lap_sec_q   <= lap_sec_d;
         lap_valid_q <= lap_valid_d;
      end
   end

   assign bus.ack0     = ack0_q;
   assign bus.ack1     = ack1_q;
   assign bus.resp_err = err_q;
   assign sw_start     = start_q;
   assign sw_stop      = stop_q;
   assign sw_reset     = reset_q;
   assign lap_min      = lap_min_q;
   assign lap_sec      = lap_sec_q;
   assign lap_valid    = lap_valid_q;
   assign ctrl_state   = state_q;

endmodule

// File: tb/tb_sw_cmd_arbiter.sv
// Scoreboard bench for sw_cmd_arbiter: a reference model predicts each grant and its response,
// and a negedge monitor pops and compares whenever an ack appears.
module tb_sw_cmd_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sw_start, sw_stop, sw_reset;
   logic [7:0] minutes = '0;
   logic [5:0] seconds = '0;
   logic [7:0] lap_min;
   logic [5:0] lap_sec;
   logic       lap_valid;
   logic [1:0] ctrl_state;

   sw_cmd_arbiter_if bus ();

   sw_cmd_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .sw_start   (sw_start),
      .sw_stop    (sw_stop),
      .sw_reset   (sw_reset),
      .minutes    (minutes),
      .seconds    (seconds),
      .lap_min    (lap_min),
      .lap_sec    (lap_sec),
      .lap_valid  (lap_valid),
      .ctrl_state (ctrl_state)
   );

   always #5 clk = ~clk;

`ifdef SWCTRL_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int         port;
      bit         err;
      bit         p_start, p_stop, p_reset;
      int         state;
      bit         lv;
      int         lmin, lsec;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: stopwatch status 0 idle, 1 running, 2 paused.
   int  m_state, m_rr, m_lmin, m_lsec;
   bit  m_lv;
   bit  m_last0, m_last1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = 0; m_rr = 0; m_lv = 0; m_lmin = 0; m_lsec = 0;
         m_last0 = 0; m_last1 = 0;
         exp_q.delete();
      end else begin
         bit   want0, want1;
         int   win, c;
         exp_t e;
         want0 = bus.req0_valid && !m_last0;
         want1 = bus.req1_valid && !m_last1;
         m_last0 = 0; m_last1 = 0;
         if (want0 || want1) begin
            if (want0 && want1) win = m_rr;
            else win = want1 ? 1 : 0;
            c = (win == 0) ? int'(bus.req0_cmd) : int'(bus.req1_cmd);
            e = '{port: win, err: 0, p_start: 0, p_stop: 0, p_reset: 0,
                  state: 0, lv: 0, lmin: 0, lsec: 0};
            case (c)
               1: if (m_state == 1) e.err = 1; else begin e.p_start = 1; m_state = 1; end
               2: if (m_state == 1) begin e.p_stop = 1; m_state = 2; end else e.err = 1;
               3: begin e.p_reset = 1; m_state = 0; m_lv = 0; m_lmin = 0; m_lsec = 0; end
               default:
                  if (LAP_EN && m_state != 0) begin
                     m_lv = 1; m_lmin = int'(minutes); m_lsec = int'(seconds);
                  end else e.err = 1;
            endcase
            e.state = m_state; e.lv = m_lv; e.lmin = m_lmin; e.lsec = m_lsec;
            exp_q.push_back(e);
            m_rr = 1 - win;
            if (win == 0) m_last0 = 1; else m_last1 = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_outputs",
             {bus.ack0, bus.ack1, bus.resp_err, sw_start, sw_stop, sw_reset,
              lap_valid, lap_min, lap_sec, ctrl_state}, '0);
      end else if (bus.ack0 || bus.ack1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_ack", {bus.ack1, bus.ack0}, 2'b00);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ack_port", {bus.ack1, bus.ack0}, (e.port == 1) ? 2'b10 : 2'b01);
            chk("resp_err", bus.resp_err, e.err);
            chk("sw_pulses", {sw_start, sw_stop, sw_reset}, {e.p_start, e.p_stop, e.p_reset});
            chk("ctrl_state", ctrl_state, e.state[1:0]);
            chk("lap", {lap_valid, lap_min, lap_sec}, {e.lv, e.lmin[7:0], e.lsec[5:0]});
         end
      end else begin
         chk("idle_no_pulse", {bus.resp_err, sw_start, sw_stop, sw_reset}, 4'b0);
         if (exp_q.size() != 0) begin
            chk("missing_ack", exp_q.size(), 0);
            exp_q.delete();
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic issue(input int p, input logic [1:0] c);
      int n;
      if (p == 0) begin bus.req0_cmd = c; bus.req0_valid = 1'b1; end
      else begin bus.req1_cmd = c; bus.req1_valid = 1'b1; end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!((p == 0) ? bus.ack0 : bus.ack1) && n < 20);
      if (n >= 20) chk("ack_timeout", 0, 1);
      if (p == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
   endtask

   task automatic issue_both(input logic [1:0] c0, input logic [1:0] c1);
      int  n;
      bit  d0, d1;
      bus.req0_cmd = c0; bus.req1_cmd = c1;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      d0 = 0; d1 = 0; n = 0;
      while (!(d0 && d1) && n < 20) begin
         @(negedge clk);
         n++;
         if (bus.ack0) begin d0 = 1; bus.req0_valid = 1'b0; end
         if (bus.ack1) begin d1 = 1; bus.req1_valid = 1'b0; end
      end
      if (n >= 20) chk("both_timeout", {d0, d1}, 2'b11);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
   endtask

   function automatic logic [1:0] rand_cmd();
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) return 2'b00;
      if (r < 6) return 2'b01;
      if (r < 9) return 2'b10;
      return 2'b11;
   endfunction

   initial begin
      int acks;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.req0_cmd = 2'b00;  bus.req1_cmd = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_state", ctrl_state, 2'b00);

      // start from port 0
      issue(0, 2'b01);
      chk("start_state", ctrl_state, 2'b01);

      // simultaneous start/stop after reset: port 0 first, then port 1
      do_reset();
      issue_both(2'b01, 2'b10);
      @(negedge clk);
      chk("both_final_state", ctrl_state, 2'b10);

      // stop while idle is rejected
      do_reset();
      issue(1, 2'b10);
      chk("stop_idle_state", ctrl_state, 2'b00);

      // lap capture then reset
      issue(0, 2'b01);
      minutes = 8'd3; seconds = 6'd45;
      issue(1, 2'b00);
      chk("lap_capture", {lap_valid, lap_min, lap_sec},
          LAP_EN ? {1'b1, 8'd3, 6'd45} : 15'd0);
      issue(0, 2'b11);
      chk("lap_cleared", {lap_valid, ctrl_state}, 3'b000);

      // reset asserted right after a grant edge
      @(negedge clk);
      bus.req0_cmd = 2'b01; bus.req0_valid = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      bus.req0_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("inflight_dropped", ctrl_state, 2'b00);

      // port 0 held valid across start, stop, start
      acks = 0;
      bus.req0_cmd = 2'b01; bus.req0_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.ack0) begin
            acks++;
            bus.req0_cmd = (acks == 1) ? 2'b10 : 2'b01;
            if (acks == 3) bus.req0_valid = 1'b0;
         end
      end
      bus.req0_valid = 1'b0;
      chk("held_valid_acks", acks, 3);
      chk("held_valid_state", ctrl_state, 2'b01);

      // randomized traffic
      for (int i = 0; i < 80; i++) begin
         int mode;
         @(negedge clk);
         minutes = 8'($urandom_range(0, 255));
         seconds = 6'($urandom_range(0, 59));
         mode = $urandom_range(0, 2);
         if (mode == 2) issue_both(rand_cmd(), rand_cmd());
         else issue(mode, rand_cmd());
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
